// File: rtl/dcache_controller_if.sv
// CPU load/store port and Data_Memory line port of the L1 data cache.
// The cache controller uses the master modport; the CPU/memory side uses slave.
interface dcache_controller_if;
  logic         p1_req_i;
  logic         p1_write_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport master (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    output p1_data_o, p1_stall_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i, mem_ack_i
  );

  modport slave (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i,
    input  p1_data_o, p1_stall_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i, mem_ack_i
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Read hits answer combinationally; misses stall the CPU while an optional
// dirty-line write-back and a line refill run over the 256-bit memory port.
module dcache_controller #(
  parameter int INDEX_BITS = 5,
  parameter int TAG_BITS   = 22
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_controller_if.master bus
);
  localparam int LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2,
    S_FILL      = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LINES-1:0]      r_valid;
  logic [LINES-1:0]      r_dirty;
  logic [TAG_BITS-1:0]   r_tag  [LINES];
  logic [255:0]          r_line [LINES];

  logic                  r_mem_enable;
  logic                  r_mem_write;
  logic [31:0]           r_mem_addr;
  logic [255:0]          r_mem_data;
  logic                  w_mem_enable_nxt;
  logic                  w_mem_write_nxt;
  logic [31:0]           w_mem_addr_nxt;
  logic [255:0]          w_mem_data_nxt;

  logic [TAG_BITS-1:0]   w_tag;
  logic [INDEX_BITS-1:0] w_index;
  logic [2:0]            w_word;
  logic [TAG_BITS-1:0]   w_old_tag;
  logic [255:0]          w_old_line;
  logic                  w_hit;
  logic                  w_write_hit;
  logic                  w_unused;

  assign w_tag       = bus.p1_addr_i[31:32-TAG_BITS];
  assign w_index     = bus.p1_addr_i[4+INDEX_BITS:5];
  assign w_word      = bus.p1_addr_i[4:2];
  assign w_old_tag   = r_tag[w_index];
  assign w_old_line  = r_line[w_index];
  assign w_hit       = bus.p1_req_i & r_valid[w_index] & (w_old_tag == w_tag);
  assign w_write_hit = (r_state == S_IDLE) & w_hit & bus.p1_write_i;
  // Byte offset bits select nothing in a word-granular cache.
  assign w_unused    = &{1'b0, bus.p1_addr_i[1:0]};

  assign bus.mem_enable_o = r_mem_enable;
  assign bus.mem_write_o  = r_mem_write;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_data_o   = r_mem_data;

  // CPU-facing stall and zero-latency load data; only IDLE can answer a request.
  always_comb begin
    bus.p1_stall_o = 1'b1;
    bus.p1_data_o  = 32'd0;
    if (r_state == S_IDLE) begin
      bus.p1_stall_o = bus.p1_req_i & ~w_hit;
      if (w_hit) begin
        bus.p1_data_o = w_old_line[{w_word, 5'b00000} +: 32];
      end else begin
        bus.p1_data_o = 32'd0;
      end
    end else begin
      bus.p1_stall_o = 1'b1;
    end
  end

  // Next state and next values of the registered memory-port outputs.
  always_comb begin
    w_state_nxt      = r_state;
    w_mem_enable_nxt = r_mem_enable;
    w_mem_write_nxt  = r_mem_write;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_data_nxt   = r_mem_data;
    case (r_state)
      S_IDLE: begin
        if (bus.p1_req_i & ~w_hit) begin
          if (r_valid[w_index] & r_dirty[w_index]) begin
            w_state_nxt      = S_WRITEBACK;
            w_mem_enable_nxt = 1'b1;
            w_mem_write_nxt  = 1'b1;
            w_mem_addr_nxt   = {w_old_tag, w_index, 5'b00000};
            w_mem_data_nxt   = w_old_line;
          end else begin
            w_state_nxt      = S_ALLOCATE;
            w_mem_enable_nxt = 1'b1;
            w_mem_write_nxt  = 1'b0;
            w_mem_addr_nxt   = {w_tag, w_index, 5'b00000};
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_WRITEBACK: begin
        // Memory is idle again right after its ack, so the fetch follows
        // back-to-back with enable held high.
        if (bus.mem_ack_i) begin
          w_state_nxt     = S_ALLOCATE;
          w_mem_write_nxt = 1'b0;
          w_mem_addr_nxt  = {w_tag, w_index, 5'b00000};
        end else begin
          w_state_nxt = S_WRITEBACK;
        end
      end
      S_ALLOCATE: begin
        // Enable must drop in the cycle after ack or memory starts again.
        if (bus.mem_ack_i) begin
          w_state_nxt      = S_FILL;
          w_mem_enable_nxt = 1'b0;
        end else begin
          w_state_nxt = S_ALLOCATE;
        end
      end
      S_FILL: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt      = S_IDLE;
        w_mem_enable_nxt = 1'b0;
        w_mem_write_nxt  = 1'b0;
      end
    endcase
  end

  // State and memory-port output registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state      <= S_IDLE;
      r_mem_enable <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_addr   <= 32'd0;
      r_mem_data   <= 256'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_mem_enable <= w_mem_enable_nxt;
      r_mem_write  <= w_mem_write_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_data   <= w_mem_data_nxt;
    end
  end

  // Valid/dirty bookkeeping: refill makes a line clean, a store hit dirties it.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_FILL) begin
      r_valid[w_index] <= 1'b1;
      r_dirty[w_index] <= 1'b0;
    end else if (w_write_hit) begin
      r_dirty[w_index] <= 1'b1;
    end
  end

  // Tag and line storage; contents are meaningless until valid is set.
  always_ff @(posedge clk_i) begin
    if (r_state == S_FILL) begin
      r_tag[w_index]  <= w_tag;
      r_line[w_index] <= bus.mem_data_i;
    end else if (w_write_hit) begin
      r_line[w_index][{w_word, 5'b00000} +: 32] <= bus.p1_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a 10-cycle line memory model and
// scoreboard queues for expected memory transactions and load data.
module tb_dcache_controller;
  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] word;
    int          widx;
  } mem_exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mem_exp_t     exp_mem_q[$];
  logic [31:0]  exp_data_q[$];
  logic [255:0] mem_lines[logic [31:0]];

  int           mdl_cnt;
  bit           fill_pending;
  logic [31:0]  fill_addr;

  dcache_controller_if bus();

  dcache_controller #(.INDEX_BITS(5), .TAG_BITS(22)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Initial memory content: word i of line a is {A0+i, a[23:0]}.
  function automatic logic [255:0] model_line(input logic [31:0] a);
    logic [255:0] l;
    if (mem_lines.exists(a)) begin
      l = mem_lines[a];
    end else begin
      for (int i = 0; i < 8; i++) begin
        l[i*32 +: 32] = 32'hA000_0000 | (32'(i) << 24) | {8'h00, a[23:0]};
      end
    end
    return l;
  endfunction

  function automatic logic [31:0] pat(input logic [31:0] a, input int i);
    logic [255:0] l;
    l = model_line(a);
    return l[i*32 +: 32];
  endfunction

  // Memory model: ack in the 10th cycle enable is high, fetch data one cycle later.
  always @(negedge clk) begin
    if (!rst_n) begin
      mdl_cnt        = 0;
      fill_pending   = 1'b0;
      bus.mem_ack_i  = 1'b0;
    end else begin
      bus.mem_ack_i = 1'b0;
      if (fill_pending) begin
        bus.mem_data_i = model_line(fill_addr);
        fill_pending   = 1'b0;
      end
      if (bus.mem_enable_o) begin
        mdl_cnt++;
        if (mdl_cnt == 10) begin
          mem_exp_t e;
          mdl_cnt       = 0;
          bus.mem_ack_i = 1'b1;
          if (exp_mem_q.size() == 0) begin
            check("mem_unexpected_txn", 256'(bus.mem_addr_o), 256'hFFFF_FFFF_FFFF);
          end else begin
            e = exp_mem_q.pop_front();
            check("mem_write", 256'(bus.mem_write_o), 256'(e.wr));
            check("mem_addr", 256'(bus.mem_addr_o), 256'(e.addr));
            if (bus.mem_write_o) begin
              if (e.wr) check("mem_wb_word", 256'(bus.mem_data_o[e.widx*32 +: 32]), 256'(e.word));
              mem_lines[bus.mem_addr_o] = bus.mem_data_o;
            end else begin
              fill_pending = 1'b1;
              fill_addr    = bus.mem_addr_o;
            end
          end
        end
      end
    end
  end

  // One CPU access starting just after a rising edge; holds inputs while stalled.
  task automatic access(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rd,
                        input int exp_stall, input int exp_en);
    int cyc    = 0;
    int en_cnt = 0;
    bit done   = 1'b0;
    bus.p1_req_i   = 1'b1;
    bus.p1_write_i = wr;
    bus.p1_addr_i  = addr;
    bus.p1_data_i  = wdata;
    if (!wr) exp_data_q.push_back(exp_rd);
    while (!done && cyc < 60) begin
      @(negedge clk);
      if (bus.mem_enable_o) en_cnt++;
      if (!bus.p1_stall_o) begin
        done = 1'b1;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    check({tag, "_done"}, 256'(done), 256'(1));
    if (done) begin
      check({tag, "_stall_cycles"}, 256'(cyc), 256'(exp_stall));
      check({tag, "_mem_idle"}, 256'(bus.mem_enable_o), 256'(0));
      check({tag, "_en_cycles"}, 256'(en_cnt), 256'(exp_en));
      if (!wr) check({tag, "_rdata"}, 256'(bus.p1_data_o), 256'(exp_data_q.pop_front()));
    end
    @(posedge clk); #1;
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
  endtask

  function automatic mem_exp_t mk(input bit wr, input logic [31:0] a, input logic [31:0] w, input int i);
    mem_exp_t e;
    e.wr = wr; e.addr = a; e.word = w; e.widx = i;
    return e;
  endfunction

  initial begin
    checks         = 0;
    failures       = 0;
    mdl_cnt        = 0;
    fill_pending   = 1'b0;
    fill_addr      = 32'd0;
    rst_n          = 1'b0;
    bus.p1_req_i   = 1'b0;
    bus.p1_write_i = 1'b0;
    bus.p1_addr_i  = 32'd0;
    bus.p1_data_i  = 32'd0;
    bus.mem_data_i = 256'd0;
    bus.mem_ack_i  = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mem_enable", 256'(bus.mem_enable_o), 256'(0));
    check("rst_mem_write", 256'(bus.mem_write_o), 256'(0));
    check("rst_mem_addr", 256'(bus.mem_addr_o), 256'(0));
    check("rst_mem_data", bus.mem_data_o, 256'd0);
    check("rst_stall", 256'(bus.p1_stall_o), 256'(0));
    check("rst_rdata", 256'(bus.p1_data_o), 256'(0));
    @(posedge clk); #1;

    // Clean load miss, then hits.
    exp_mem_q.push_back(mk(1'b0, 32'h40, 32'h0, 0));
    access("ld40_miss", 1'b0, 32'h40, 32'h0, pat(32'h40, 0), 12, 10);
    access("ld44_hit", 1'b0, 32'h44, 32'h0, pat(32'h40, 1), 0, 0);
    access("st48_hit", 1'b1, 32'h48, 32'hDEAD_BEEF, 32'h0, 0, 0);
    access("ld48_hit", 1'b0, 32'h48, 32'h0, 32'hDEAD_BEEF, 0, 0);

    // Dirty conflict miss: write-back of 0x40, then fetch 0x440.
    exp_mem_q.push_back(mk(1'b1, 32'h40, 32'hDEAD_BEEF, 2));
    exp_mem_q.push_back(mk(1'b0, 32'h440, 32'h0, 0));
    access("ld440_dirty", 1'b0, 32'h440, 32'h0, pat(32'h440, 0), 22, 20);

    // Refetch of 0x40 returns the written-back store data.
    exp_mem_q.push_back(mk(1'b0, 32'h40, 32'h0, 0));
    access("ld48_refetch", 1'b0, 32'h48, 32'h0, 32'hDEAD_BEEF, 12, 10);

    // Reset during cycle 5 of an ALLOCATE.
    exp_mem_q.push_back(mk(1'b0, 32'h60, 32'h0, 0));
    bus.p1_req_i  = 1'b1;
    bus.p1_addr_i = 32'h60;
    repeat (5) @(posedge clk);
    #1;
    check("alloc_mid_enable", 256'(bus.mem_enable_o), 256'(1));
    rst_n        = 1'b0;
    bus.p1_req_i = 1'b0;
    #1;
    check("rst_mid_enable", 256'(bus.mem_enable_o), 256'(0));
    check("rst_mid_write", 256'(bus.mem_write_o), 256'(0));
    check("rst_mid_addr", 256'(bus.mem_addr_o), 256'(0));
    check("rst_mid_stall", 256'(bus.p1_stall_o), 256'(0));
    repeat (2) @(posedge clk);
    exp_mem_q.delete();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    exp_mem_q.push_back(mk(1'b0, 32'h40, 32'h0, 0));
    access("ld44_after_rst", 1'b0, 32'h44, 32'h0, pat(32'h40, 1), 12, 10);

    // Clean store miss, then a conflict that writes the stored word back.
    exp_mem_q.push_back(mk(1'b0, 32'h80, 32'h0, 0));
    access("st80_miss", 1'b1, 32'h80, 32'h1234_5678, 32'h0, 12, 10);
    exp_mem_q.push_back(mk(1'b1, 32'h80, 32'h1234_5678, 0));
    exp_mem_q.push_back(mk(1'b0, 32'h480, 32'h0, 0));
    access("ld480_dirty", 1'b0, 32'h480, 32'h0, pat(32'h480, 0), 22, 20);

    check("mem_q_drained", 256'(exp_mem_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache controller.
- Sits between the CPU load/store port (p1_*) and Data_Memory. It is the initiator side of the enable/write/ack 256-bit line protocol that Data_Memory responds to.
- Holds the tag, valid, dirty and 256-bit line storage internally.
- Stalls the CPU on a miss while it performs a write-back and/or a line refill.

Parameters:
INDEX_BITS, 5, line index width (2^INDEX_BITS lines; default 32 lines = 1 KB).
TAG_BITS, 22, tag width; must equal 32-5-INDEX_BITS.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
p1_req_i  in  1  CPU access request
p1_write_i  in  1  1=store, 0=load
p1_addr_i  in  32  byte address; [4:2] word select, [1:0] ignored
p1_data_i  in  32  store data
p1_data_o  out  32  load data
p1_stall_o  out  1  CPU must hold request and inputs stable while high
mem_enable_o  out  1  memory transaction request
mem_write_o  out  1  1=line write-back, 0=line fetch
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  256  write-back line
mem_data_i  in  256  fetched line
mem_ack_i  in  1  memory done (single-cycle pulse)

Behaviour:
- Address split: tag=addr[31:32-TAG_BITS], index=addr[4+INDEX_BITS:5], word=addr[4:2].
- Reset (async, rst_i=0):
  - State goes to IDLE.
  - All valid and dirty bits clear; tag/data contents are don't-care.
  - mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0.
  - Reset mid-transaction abandons it with no partial line update. Data_Memory shares rst_i, so both ends return to idle together.
- hit = p1_req_i & valid[index] & (tag[index]==tag).
- p1_stall_o (combinational):
  - In IDLE: p1_req_i & ~hit.
  - In every other state: 1.
- p1_data_o:
  - In IDLE with a hit: selected word of the line.
  - Otherwise: 0.
- States IDLE, WRITEBACK, ALLOCATE, FILL. All mem_* outputs are registered.
- IDLE:
  - Read hit: zero-latency response, no state change.
  - Write hit: word written at the clock edge, dirty set, stall 0.
  - Miss, line dirty and valid:
    - Go WRITEBACK.
    - mem_enable_o=1, mem_write_o=1.
    - mem_addr_o={old tag, index, 5'b0}.
    - mem_data_o=old line.
  - Miss, otherwise:
    - Go ALLOCATE.
    - mem_enable_o=1, mem_write_o=0.
    - mem_addr_o={tag, index, 5'b0}.
- WRITEBACK:
  - Hold all mem_* outputs until mem_ack_i.
  - On the ack cycle: go ALLOCATE, keep mem_enable_o=1, set mem_write_o=0 and mem_addr_o={new tag, index, 0}.
  - Memory is back in idle on the next cycle and samples the new write/addr, so no gap cycle is needed.
- ALLOCATE:
  - Hold outputs until mem_ack_i.
  - On the ack cycle: mem_enable_o<=0 and go FILL.
  - mem_enable_o must be low in the cycle after ack, otherwise memory starts a spurious transaction.
- FILL:
  - Memory presents read data on mem_data_i in the cycle after ack.
  - Capture mem_data_i into the line; write tag; valid=1, dirty=0.
  - Go IDLE, where the held request re-evaluates as a hit (a store then writes and sets dirty).
- Latency, given the 10-cycle memory (ack in the 10th WAIT cycle), with cycle 0 as the request cycle:
  - Clean miss: ALLOCATE cycles 1-10, FILL cycle 11, hit at cycle 12; p1_stall_o high cycles 0-11.
  - Dirty miss: WRITEBACK cycles 1-10, ALLOCATE 11-20, FILL 21, hit at 22.
- mem_ack_i outside WRITEBACK/ALLOCATE is ignored.
- p1_req_i deasserted in IDLE: no action.
- Requests are not re-sampled while not in IDLE.

Test Plan:
1. Reset, then load 0x0000_0040 (index 2) with memory line 0x40 = words W0..W7.
   - mem_enable_o=1, mem_write_o=0, mem_addr_o=0x40 from cycle 1.
   - Stall cycles 0-11; p1_data_o=W0 at cycle 12.
2. Load 0x44 next: hit, stall 0, p1_data_o=W1, mem_enable_o stays 0.
3. Store 0xDEADBEEF to 0x48: hit, no memory traffic. Then load 0x48 -> 0xDEADBEEF.
4. Load 0x440 (same index 2, different tag):
   - Write-back with mem_write_o=1, mem_addr_o=0x40, mem_data_o word2=0xDEADBEEF.
   - Then fetch with mem_addr_o=0x440 and write 0.
   - mem_enable_o high continuously cycles 1-20; stall through cycle 21; data valid at cycle 22.
5. Pull rst_i low during cycle 5 of an ALLOCATE:
   - mem_enable_o=0 and p1_stall_o reflects IDLE immediately.
   - After release, load 0x44 misses (valid cleared).
6. Clean store miss to 0x80 data 0x12345678:
   - Fetch line 0x80, FILL, store applied at cycle 12, dirty set.
   - A later conflicting access to 0x480 writes back 0x80 with word0=0x12345678.
